// File: rtl/fsm_stream_arbiter.sv
// Round-robin arbiter that time-shares one sequence-detector FSM among N_REQ requesters:
// per grant it clears the detector, streams the pattern MSB first and counts yout hits.
module fsm_stream_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 8,
  parameter int HIT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BURST_LEN-1:0] pat,
  input  logic                       yout_in,
  output logic                       fsm_clr,
  output logic                       ain_out,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [HIT_W-1:0]           hits,
  output logic                       busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, gnt_idx, pick, cand;
  logic                 found;
  logic [BURST_LEN-1:0] sreg;
  logic [BURST_LEN-1:0] pat_arr [N_REQ];
  logic [HIT_W-1:0]     bit_cnt;
  logic                 last_bit;

  assign last_bit = (bit_cnt == HIT_W'(BURST_LEN - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      pat_arr[i] = pat[i*BURST_LEN +: BURST_LEN];
    end
  end

  // Search starts just past the last served requester, so every waiting one is reached.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = CLEAR;
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs are registered so the detector sees glitch-free clear and data lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt     <= '0;
      done    <= '0;
      hits    <= '0;
      ain_out <= 1'b0;
      fsm_clr <= 1'b0;
      rr_ptr  <= PTR_W'(N_REQ - 1);
      gnt_idx <= '0;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      done    <= '0;
      fsm_clr <= 1'b0;
      ain_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt     <= N_REQ'(1) << pick;
            gnt_idx <= pick;
            sreg    <= pat_arr[pick];
            hits    <= '0;
            bit_cnt <= '0;
            fsm_clr <= 1'b1;
          end
        end
        CLEAR: begin
          ain_out <= sreg[BURST_LEN-1];
          sreg    <= sreg << 1;
        end
        SHIFT: begin
          hits <= hits + HIT_W'(yout_in);
          if (last_bit) begin
            done <= N_REQ'(1) << gnt_idx;
          end else begin
            ain_out <= sreg[BURST_LEN-1];
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        REPORT: begin
          gnt    <= '0;
          rr_ptr <= gnt_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
